// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding, select encodings and byte width
// for the UART transmit arbiter and its arbitration sub-module.
package uart_tx_arb_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT,
      DONE
   } state_t;

   localparam logic [1:0] SEL_A = 2'b00;
   localparam logic [1:0] SEL_B = 2'b01;
   localparam logic [1:0] SEL_C = 2'b10;
   localparam logic [1:0] SEL_D = 2'b11;

   // Turn a requester index into its one-hot ack position.
   function automatic logic [3:0] sel_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way arbiter.
// Default build: round-robin, search starts at (last + 1) mod 4.
// With UART_TX_ARB_FIXED_PRIO_EN defined: fixed priority A > B > C > D and
// 'last' is ignored.
module rr_arb4
   import uart_tx_arb_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant,
   output logic       valid
);

   assign valid = |req;

   // NOTE: every variable written in an always_comb gets a default first so no path infers a latch.
`ifdef UART_TX_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;

   // Scan from D down to A so the lowest index overrides and wins.
   always_comb begin
      grant = SEL_A;
      for (int i = 3; i >= 0; i--) begin
         if (req[i]) grant = i[1:0];
      end
   end
`else
   logic [1:0] idx;

   // Scan from the farthest candidate to the nearest so (last + 1) overrides and wins.
   always_comb begin
      grant = SEL_A;
      idx   = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + k[1:0];
         if (req[idx]) grant = idx;
      end
   end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: picks one of four requesters, captures its LENGTH-bit
// word and streams it LSB-byte-first to a UART transmitter, then acks it.
// Optional build macro UART_TX_ARB_FIXED_PRIO_EN switches the arbiter from
// round-robin to fixed priority A > B > C > D.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int LENGTH = 32,
   parameter int NREQ   = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [LENGTH-1:0] data_a,
   input  logic [LENGTH-1:0] data_b,
   input  logic [LENGTH-1:0] data_c,
   input  logic [LENGTH-1:0] data_d,
   input  logic              tx_busy,
   output logic [NREQ-1:0]   ack,
   output logic [1:0]        sel,
   output logic              mux_en,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_start,
   output logic              busy
);

   localparam int                NBYTES   = LENGTH / BYTE_W;
   localparam int                CNT_W    = 3;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NBYTES);

   state_t              state;
   state_t              state_next;
   logic [1:0]          last_q;
   logic [LENGTH-1:0]   shreg;
   logic [LENGTH-1:0]   word_sel;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_inc;
   logic                wait_armed;
   logic                shift_done;
   logic [1:0]          grant;
   logic                grant_valid;

   rr_arb4 u_arb (
      .req   (req),
      .last  (last_q),
      .grant (grant),
      .valid (grant_valid)
   );

   // Word mux driven by the registered select.
   always_comb begin
      word_sel = data_a;
      case (sel)
         SEL_A:   word_sel = data_a;
         SEL_B:   word_sel = data_b;
         SEL_C:   word_sel = data_c;
         SEL_D:   word_sel = data_d;
         default: word_sel = data_a;
      endcase
   end

   // The first WAIT cycle is skipped because tx_busy has not risen yet.
   assign shift_done = (state == WAIT) && wait_armed && !tx_busy;
   assign cnt_inc    = cnt + 1'b1;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = LOAD;
         LOAD:    state_next = SEND;
         SEND:    state_next = WAIT;
         WAIT:    if (shift_done) state_next = (cnt_inc == CNT_LAST) ? DONE : SEND;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      mux_en   = 1'b0;
      tx_start = 1'b0;
      tx_data  = '0;
      ack      = '0;
      busy     = (state != IDLE);
      case (state)
         LOAD: mux_en = 1'b1;
         SEND: begin
            tx_start = 1'b1;
            tx_data  = shreg[BYTE_W-1:0];
         end
         DONE: ack = sel_onehot(sel);
         default: ;
      endcase
   end

   // Datapath: grant capture, word shift register, byte counter, history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel        <= SEL_A;
         last_q     <= SEL_D;
         // NOTE: the word register is reset too, so a word abandoned by rst leaves no stale bytes behind.
         shreg      <= '0;
         cnt        <= '0;
         wait_armed <= 1'b0;
      end else begin
         case (state)
            IDLE: if (grant_valid) sel <= grant;
            LOAD: begin
               shreg <= word_sel;
               cnt   <= '0;
            end
            SEND: wait_armed <= 1'b0;
            WAIT: begin
               wait_armed <= 1'b1;
               if (shift_done) begin
                  shreg <= shreg >> BYTE_W;
                  cnt   <= cnt_inc;
               end
            end
            DONE: last_q <= sel;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench. A timeline model computes, at each
// grant, the cycle of every LOAD, tx_start and ack from the UART busy lengths
// the bench itself chooses; outputs are compared against it every cycle.
module tb_uart_tx_arbiter;

   localparam int LEN = 32;
   localparam int NB  = LEN / 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req;
   logic [LEN-1:0] data_a, data_b, data_c, data_d;
   logic           tx_busy;
   logic [3:0]     ack;
   logic [1:0]     sel;
   logic           mux_en, tx_start, busy;
   logic [7:0]     tx_data;

   logic [3:0]     req8;
   logic [7:0]     d8_a, d8_b, d8_c, d8_d;
   logic           tx_busy8;
   logic [3:0]     ack8;
   logic [1:0]     sel8;
   logic           mux_en8, tx_start8, busy8;
   logic [7:0]     tx_data8;

   uart_tx_arbiter #(.LENGTH(LEN), .NREQ(4)) dut (
      .clk(clk), .rst(rst), .req(req),
      .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
      .tx_busy(tx_busy), .ack(ack), .sel(sel), .mux_en(mux_en),
      .tx_data(tx_data), .tx_start(tx_start), .busy(busy)
   );

   uart_tx_arbiter #(.LENGTH(8), .NREQ(4)) dut8 (
      .clk(clk), .rst(rst), .req(req8),
      .data_a(d8_a), .data_b(d8_b), .data_c(d8_c), .data_d(d8_d),
      .tx_busy(tx_busy8), .ack(ack8), .sel(sel8), .mux_en(mux_en8),
      .tx_data(tx_data8), .tx_start(tx_start8), .busy(busy8)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Timeline model of the word in flight.
   bit         m_active = 1'b0;
   int         m_g, m_w, m_ack_t;
   int         m_st[NB];
   int         m_bl[NB];
   logic [7:0] m_bv[NB];
   int         m_last = 3;
   logic [1:0] m_sel  = 2'b00;
   int         m_done = 0;
   logic [3:0] clr_pend = 4'b0000;

   bit rand_req = 1'b0, rand_data = 1'b0, auto_clear = 1'b1;
   int busy_min = 1, busy_max = 6;

   int         mdl_grants[$];
   logic [7:0] mdl_bytes[$];
   int         obs_grants[$];
   logic [7:0] obs_bytes[$];
   int         ack_cnt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL timeout %s: condition not reached (cycle %0d)", name, cyc);
   endtask

   function automatic int winner(input logic [3:0] r, input int last);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
      return 0;
   endfunction

   function automatic logic [31:0] word_of(input int i);
      case (i)
         0: return data_a;
         1: return data_b;
         2: return data_c;
         default: return data_d;
      endcase
   endfunction

   // UART model: busy for the chosen length after each scheduled tx_start.
   function automatic logic sched_busy();
      if (!m_active) return 1'b0;
      for (int k = 0; k < NB; k++)
         if (cyc > m_st[k] && cyc <= m_st[k] + m_bl[k]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick_begin();
      logic [3:0] cl;
      @(posedge clk);
      cyc++;
      #1;
      cl       = clr_pend;
      clr_pend = 4'b0000;
      for (int i = 0; i < 4; i++) if (cl[i]) req[i] = 1'b0;
      if (rand_req) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && !cl[i] && $urandom_range(3) == 0) req[i] = 1'b1;
            else if (req[i] && m_active && i == m_w && cyc > m_g + 2 && $urandom_range(15) == 0)
               req[i] = 1'b0;
         end
      end
      if (rand_data) begin
         if ($urandom_range(1) == 1) data_a = $urandom;
         if ($urandom_range(1) == 1) data_b = $urandom;
         if ($urandom_range(1) == 1) data_c = $urandom;
         if ($urandom_range(1) == 1) data_d = $urandom;
      end
      tx_busy = sched_busy();
   endtask

   task automatic tick_end();
      logic [31:0] w;
      bit          e_start;
      int          e_k;
      logic [3:0]  e_ack;
      @(negedge clk);
      if (m_active && cyc == m_g + 1) begin
         w = word_of(m_w);
         for (int k = 0; k < NB; k++) begin
            m_bv[k] = w[8*k +: 8];
            mdl_bytes.push_back(m_bv[k]);
         end
      end
      e_start = 1'b0;
      e_k     = 0;
      if (m_active)
         for (int k = 0; k < NB; k++) if (cyc == m_st[k]) begin e_start = 1'b1; e_k = k; end
      e_ack = (m_active && cyc == m_ack_t) ? (4'b0001 << m_w) : 4'b0000;
      check("sel", sel, m_sel);
      check("busy", busy, m_active);
      check("mux_en", mux_en, m_active && cyc == m_g + 1);
      check("tx_start", tx_start, e_start);
      if (e_start) check("tx_data", tx_data, m_bv[e_k]);
      check("ack", ack, e_ack);
      if (tx_start) obs_bytes.push_back(tx_data);
      if (mux_en) obs_grants.push_back(int'(sel));
      for (int i = 0; i < 4; i++) if (ack[i]) ack_cnt[i]++;
      // Advance the model using the request seen this cycle.
      if (m_active && cyc == m_ack_t) begin
         m_active = 1'b0;
         m_last   = m_w;
         m_done++;
         if (auto_clear) clr_pend[m_w] = 1'b1;
      end else if (!m_active && req != 4'b0000) begin
         int t;
         m_w      = winner(req, m_last);
         m_g      = cyc;
         m_active = 1'b1;
         m_sel    = m_w[1:0];
         mdl_grants.push_back(m_w);
         t = cyc + 2;
         for (int k = 0; k < NB; k++) begin
            m_st[k] = t;
            m_bl[k] = $urandom_range(busy_max, busy_min);
            t       = t + m_bl[k] + 2;
         end
         m_ack_t = t;
      end
   endtask

   task automatic step();
      tick_begin();
      tick_end();
   endtask

   task automatic wait_idle(input int max, input string name);
      int n = 0;
      while ((m_active || req != 4'b0000) && n < max) begin step(); n++; end
      if (m_active || req != 4'b0000) fail_timeout(name);
   endtask

   task automatic clear_obs();
      mdl_grants.delete(); mdl_bytes.delete();
      obs_grants.delete(); obs_bytes.delete();
      for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
   endtask

   task automatic check_bytes(input string name, input logic [31:0] word);
      check({name, "_mdl_n"}, mdl_bytes.size(), 4);
      check({name, "_obs_n"}, obs_bytes.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < mdl_bytes.size()) check({name, "_mdl_byte"}, mdl_bytes[k], word[8*k +: 8]);
         if (k < obs_bytes.size()) check({name, "_obs_byte"}, obs_bytes[k], word[8*k +: 8]);
      end
   endtask

   task automatic t_len8();
      int n_mux = 0, n_start = 0, n_ack = 0, cd = 0;
      bit drop  = 1'b0;
      @(posedge clk); #1;
      req8 = 4'b1000; d8_a = 8'h11; d8_b = 8'h22; d8_c = 8'h33; d8_d = 8'h5A;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (mux_en8) begin n_mux++; check("len8_sel_in_load", sel8, 2'b11); end
         if (tx_start8) begin n_start++; check("len8_tx_data", tx_data8, 8'h5A); cd = 3; end
         if (ack8 != 4'b0000) begin n_ack++; check("len8_ack", ack8, 4'b1000); drop = 1'b1; end
         @(posedge clk); #1;
         if (n_mux > 0) d8_d = 8'hA5;
         if (drop) req8 = 4'b0000;
         tx_busy8 = (cd > 0);
         if (cd > 0) cd--;
      end
      check("len8_mux_en_pulses", n_mux, 1);
      check("len8_tx_start_pulses", n_start, 1);
      check("len8_ack_pulses", n_ack, 1);
      check("len8_busy_end", busy8, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_g[5];
      int n;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0, 0};
`else
      exp_g = '{0, 1, 2, 3, 0};
`endif
      rst = 1'b1; req = 4'b0000; tx_busy = 1'b0;
      data_a = '0; data_b = '0; data_c = '0; data_d = '0;
      req8 = 4'b0000; tx_busy8 = 1'b0; d8_a = '0; d8_b = '0; d8_c = '0; d8_d = '0;
      #1;
      check("rst_sel", sel, 2'b00);
      check("rst_mux_en", mux_en, 1'b0);
      check("rst_tx_start", tx_start, 1'b0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_ack", ack, 4'b0000);
      check("rst_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // All four requesting and held: round-robin order from A.
      clear_obs();
      auto_clear = 1'b0; busy_min = 1; busy_max = 3;
      tick_begin(); req = 4'b1111; tick_end();
      n = 0;
      while (m_done < 5 && n < 500) begin step(); n++; end
      if (m_done < 5) fail_timeout("rr_five_words");
      tick_begin(); req = 4'b0000; tick_end();
      auto_clear = 1'b1;
      wait_idle(200, "rr_drain");
      check("rr_grant_count", obs_grants.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < mdl_grants.size()) check("rr_model_order", mdl_grants[i], exp_g[i]);
         if (i < obs_grants.size()) check("rr_dut_order", obs_grants[i], exp_g[i]);
      end

      // Single requester A, 10-cycle UART frames.
      clear_obs();
      busy_min = 10; busy_max = 10;
      tick_begin(); data_a = 32'h11223344; req = 4'b0001; tick_end();
      wait_idle(400, "word_a");
      check_bytes("word_a", 32'h11223344);
      check("word_a_ack_a", ack_cnt[0], 1);
      check("word_a_ack_other", ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 0);

      // Requester C changes its word right after LOAD.
      clear_obs();
      busy_min = 2; busy_max = 4;
      tick_begin(); data_c = 32'hA1B2C3D4; req = 4'b0100; tick_end();
      n = 0;
      while (!(m_active && cyc > m_g + 1) && n < 20) begin step(); n++; end
      n = 0;
      while (m_active && n < 200) begin
         tick_begin(); data_c = $urandom; tick_end(); n++;
      end
      wait_idle(50, "word_c");
      check_bytes("word_c", 32'hA1B2C3D4);

      // Requester B withdraws after the first byte; the word still completes.
      clear_obs();
      tick_begin(); data_b = 32'hCAFE0102; req = 4'b0010; tick_end();
      n = 0;
      while (m_active && cyc <= m_st[0] && n < 20) begin step(); n++; end
      tick_begin(); req[1] = 1'b0; tick_end();
      wait_idle(200, "word_b_drop");
      check_bytes("word_b_drop", 32'hCAFE0102);
      check("word_b_drop_ack", ack_cnt[1], 1);

      // Reset after the second byte of a C word.
      clear_obs();
      tick_begin(); data_c = 32'h55667788; req = 4'b0100; tick_end();
      n = 0;
      while (m_active && cyc <= m_st[1] && n < 50) begin step(); n++; end
      @(posedge clk);
      #2 rst = 1'b1;
      tx_busy = 1'b0;
      #1;
      check("mid_rst_sel", sel, 2'b00);
      check("mid_rst_mux_en", mux_en, 1'b0);
      check("mid_rst_tx_start", tx_start, 1'b0);
      check("mid_rst_tx_data", tx_data, 8'h00);
      check("mid_rst_ack", ack, 4'b0000);
      check("mid_rst_busy", busy, 1'b0);
      req = 4'b0000;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      m_active = 1'b0; m_last = 3; m_sel = 2'b00; clr_pend = 4'b0000;
      repeat (4) step();
      check("mid_rst_no_ack", ack_cnt[2], 0);
      check("mid_rst_bytes_before", obs_bytes.size(), 2);
      mdl_grants.delete(); obs_grants.delete();
      tick_begin(); req = 4'b1111; tick_end();
      n = 0;
      while (obs_grants.size() == 0 && n < 10) begin step(); n++; end
      if (mdl_grants.size() > 0) check("post_rst_model_grant", mdl_grants[0], 0);
      if (obs_grants.size() > 0) check("post_rst_dut_grant", obs_grants[0], 0);
      else fail_timeout("post_rst_grant");
      wait_idle(1000, "post_rst_drain");

      // Randomized traffic against the timeline model.
      rand_req = 1'b1; rand_data = 1'b1; busy_min = 1; busy_max = 6;
      repeat (1500) step();
      rand_req = 1'b0; rand_data = 1'b0;
      wait_idle(3000, "random_drain");

      // 8-bit word instance: a single frame per word.
      t_len8();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter LENGTH, default 32, meaning width of each requester word (multiple of 8, 8..32).
REQ-002 SHALL have parameter NREQ, fixed 4, meaning number of requesters.
REQ-003 SHALL have port clk  input  1  single system clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  4  per-requester transmit request, level, held until ack.
REQ-006 SHALL have port data_a..data_d  input  LENGTH each  requester words.
REQ-007 SHALL have port ack  output  4  one-cycle pulse to the requester whose word finished.
REQ-008 SHALL have port sel  output  2  word-mux select, 00=A, 01=B, 10=C, 11=D.
REQ-009 SHALL have port mux_en  output  1  word-mux enable; high only in LOAD.
REQ-010 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-011 SHALL have port tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-012 SHALL have port tx_busy  input  1  UART transmitter busy, high from the cycle after tx_start until the frame ends.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, LOAD, SEND, WAIT, DONE.
REQ-015 IDLE: when any req bit is high, SHALL register the winner in sel and go to LOAD next cycle.
REQ-016 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod 4; after reset, last granted = 3, so A wins first.
REQ-017 LOAD: mux_en=1 for exactly one cycle; the selected word SHALL be captured into an internal shift register; byte counter cleared; go to SEND.
REQ-018 SEND: tx_data = shift register [7:0], tx_start=1 for one cycle, go to WAIT.
REQ-019 WAIT: when tx_busy=0 (checked from the 2nd WAIT cycle on), shift register shifts right 8, counter increments; if counter reaches LENGTH/8 go to DONE, else SEND.
REQ-020 Bytes SHALL be sent LSB first; one word = LENGTH/8 frames.
REQ-021 DONE: ack[sel]=1 for one cycle, last-granted updated to sel, go to IDLE.
REQ-022 Minimum idle gap between consecutive words SHALL be 1 cycle (DONE->IDLE->LOAD).
REQ-023 Deasserting req of the granted requester mid-word SHALL NOT abort the word; ack still issues.
REQ-024 Requests arriving during a word SHALL be held pending and not affect sel until IDLE.
REQ-025 The requester input word SHALL be sampled only in LOAD; later changes do not affect transmitted bytes.
REQ-026 Simultaneous req on all four SHALL be served A,B,C,D,A,... when held continuously.

Reset
REQ-027 On rst high, immediately: state=IDLE, sel=00, mux_en=0, tx_start=0, tx_data=0, ack=0, busy=0, counter=0, shift register=0, last granted=3.
REQ-028 Reset mid-word SHALL abandon the word without ack; no tx_start after rst deasserts until a new grant.

Configuration
REQ-029 Macro UART_TX_ARB_FIXED_PRIO_EN defined: arbitration SHALL be fixed priority A>B>C>D, last-granted ignored.
REQ-030 Macro undefined: round-robin per REQ-016.

Structure
REQ-031 Package uart_tx_arb_pkg SHALL hold the state enum, sel encodings SEL_A..SEL_D, and BYTE_W=8.
REQ-032 Arbitration SHALL be a sub-module rr_arb4 (req, last, grant index, valid), combinational, selected by the macro.

Verification
REQ-033 req=0001, data_a=0x11223344, tx_busy 10 cycles per frame -> tx_data 0x44,0x33,0x22,0x11 in order, then ack=0001 once.
REQ-034 req=1111 held -> grants in order A,B,C,D,A; with macro defined -> A repeatedly.
REQ-035 req=0100 granted, data_c changed after LOAD -> transmitted bytes equal value at LOAD.
REQ-036 rst asserted after 2nd byte -> all outputs zero same cycle, no ack, next grant restarts from A.
REQ-037 req=0010 dropped after SEND of byte 1 -> all 4 bytes sent, ack=0010.
REQ-038 LENGTH=8, req=1000 -> single tx_start, ack=1000, sel=11 during LOAD with mux_en=1 one cycle.
